// File: rtl/seg7_readback_pkg.sv
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared glyph table, state encoding and widths for the
//             seven-segment readback block. Glyphs are active-low, listed
//             as segments a..g (index 0 = segment a).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  // Active-low glyphs, segment order a..g
  localparam logic [0:6] c_glyph_0 = 7'b0000001;
  localparam logic [0:6] c_glyph_1 = 7'b1001111;
  localparam logic [0:6] c_glyph_2 = 7'b0010010;
  localparam logic [0:6] c_glyph_3 = 7'b0000110;
  localparam logic [0:6] c_glyph_4 = 7'b1001100;
  localparam logic [0:6] c_glyph_5 = 7'b0100100;
  localparam logic [0:6] c_glyph_6 = 7'b0100000;
  localparam logic [0:6] c_glyph_7 = 7'b0001111;
  localparam logic [0:6] c_glyph_8 = 7'b0000000;
  localparam logic [0:6] c_glyph_9 = 7'b0001100;
  localparam logic [0:6] c_glyph_a = 7'b0001000;
  localparam logic [0:6] c_glyph_b = 7'b1100000;
  localparam logic [0:6] c_glyph_c = 7'b0110001;
  localparam logic [0:6] c_glyph_d = 7'b1000010;
  localparam logic [0:6] c_glyph_e = 7'b0110000;
  localparam logic [0:6] c_glyph_f = 7'b0111000;

  // All segments dark
  localparam logic [0:6] c_blank = 7'b1111111;

  // Stability counter width: holds any STABLE_CYCLES in 1..255
  localparam int c_cnt_w = 8;

  // Number of digits and full sample width
  localparam int c_digits  = 4;
  localparam int c_pat_w   = 7 * c_digits;

  // IDLE  : nothing accepted since reset or since the last accepted blank
  // SETTLE: a new pattern is being qualified
  // HOLD  : current pattern already handled, waiting for a change
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Modulo-2^16 successor used for step detection
  function automatic logic [15:0] seg7_succ(input logic [15:0] v);
    return v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_readback_glyph_decode.sv
// ============================================================================
//  Module   : seg7_glyph_decode
//  Purpose  : Combinational decode of one active-low seven-segment glyph
//             into a hex nibble, with legal and blank indications.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [0:6] i_pattern,
  output logic [3:0] o_nibble,
  output logic       o_legal,
  output logic       o_blank
);

  // Map the glyph back to its nibble; anything outside the table is illegal
  always_comb begin
    o_nibble = 4'h0;
    o_legal  = 1'b1;
    case (i_pattern)
      c_glyph_0: o_nibble = 4'h0;
      c_glyph_1: o_nibble = 4'h1;
      c_glyph_2: o_nibble = 4'h2;
      c_glyph_3: o_nibble = 4'h3;
      c_glyph_4: o_nibble = 4'h4;
      c_glyph_5: o_nibble = 4'h5;
      c_glyph_6: o_nibble = 4'h6;
      c_glyph_7: o_nibble = 4'h7;
      c_glyph_8: o_nibble = 4'h8;
      c_glyph_9: o_nibble = 4'h9;
      c_glyph_a: o_nibble = 4'ha;
      c_glyph_b: o_nibble = 4'hb;
      c_glyph_c: o_nibble = 4'hc;
      c_glyph_d: o_nibble = 4'hd;
      c_glyph_e: o_nibble = 4'he;
      c_glyph_f: o_nibble = 4'hf;
      default:   o_legal  = 1'b0;
    endcase
  end

  // A dark digit is reported separately so the top can spot an all-blank display
  assign o_blank = (i_pattern == c_blank);

endmodule

`default_nettype wire

// File: rtl/seg7_readback.sv
// ============================================================================
//  Module   : seg7_readback
//  Purpose  : Reads four active-low seven-segment digits back into a 16-bit
//             value once the pattern has been stable for STABLE_CYCLES
//             enabled samples. Flags illegal glyphs and +1 steps.
//  Options  : SEG7_READBACK_ERRCNT_EN - saturating 8-bit error counter on
//             ErrCount; when undefined ErrCount is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_readback
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
)
(
  input  logic         Clk,
  input  logic         Clr,
  input  logic         En,
  input  logic [0:6]   Disp0,
  input  logic [0:6]   Disp1,
  input  logic [0:6]   Disp2,
  input  logic [0:6]   Disp3,
  output logic [15:0]  Value,
  output logic         Valid,
  output logic         Step,
  output logic         Err,
  output logic [7:0]   ErrCount
);

  localparam logic [c_cnt_w:0] c_stable = (c_cnt_w + 1)'(STABLE_CYCLES);
  localparam logic [c_pat_w-1:0] c_all_blank = {c_digits{c_blank}};

  // --------------------------------------------------------------------------
  // Sample path
  // --------------------------------------------------------------------------
  logic [c_pat_w-1:0] w_pat;
  logic [c_pat_w-1:0] r_sample;
  logic [c_cnt_w-1:0] r_cnt;
  state_t             r_state;

  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_cnt_w:0]   w_cnt_inc;
  state_t             w_state_nxt;
  logic               w_changed;
  logic               w_accept;

  // Digit 3 occupies the top seven bits, digit 0 the bottom seven
  assign w_pat = {Disp3, Disp2, Disp1, Disp0};

  // --------------------------------------------------------------------------
  // Per-digit decode
  // --------------------------------------------------------------------------
  logic [3:0]          w_nib [c_digits];
  logic [c_digits-1:0] w_legal;
  logic [c_digits-1:0] w_blank;
  logic [15:0]         w_decoded;
  logic                w_all_legal;
  logic                w_all_blank;

  for (genvar gi = 0; gi < c_digits; gi++) begin : g_digit
    seg7_glyph_decode u_decode (
      .i_pattern (w_pat[7*gi +: 7]),
      .o_nibble  (w_nib[gi]),
      .o_legal   (w_legal[gi]),
      .o_blank   (w_blank[gi])
    );
  end

  assign w_decoded   = {w_nib[3], w_nib[2], w_nib[1], w_nib[0]};
  assign w_all_legal = &w_legal;
  assign w_all_blank = &w_blank;

  assign w_changed = (w_pat != r_sample);
  assign w_cnt_inc = {1'b0, r_cnt} + {{c_cnt_w{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State register: sample, stability counter and FSM state
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      r_sample <= c_all_blank;
      r_cnt    <= '0;
      r_state  <= IDLE;
    end else if (En) begin
      r_sample <= w_pat;
      r_cnt    <= w_cnt_nxt;
      r_state  <= w_state_nxt;
    end
  end

  // Next state: restart qualification on any change, count while stable
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (w_changed) begin
      w_cnt_nxt   = {{(c_cnt_w-1){1'b0}}, 1'b1};
      w_state_nxt = SETTLE;
      // A single-sample qualification accepts on the change edge itself
      if (STABLE_CYCLES == 1) begin
        w_accept = 1'b1;
      end
    end else if (r_state == SETTLE) begin
      w_cnt_nxt = w_cnt_inc[c_cnt_w-1:0];
      if (w_cnt_inc == c_stable) begin
        w_accept = 1'b1;
      end
    end
    // An accepted blank returns to IDLE so the next value counts as first
    if (w_accept) begin
      w_state_nxt = w_all_blank ? IDLE : HOLD;
    end
    // Disabled edges neither advance the FSM nor accept anything
    if (!En) begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output path
  // --------------------------------------------------------------------------
  logic [15:0] r_value;
  logic        r_valid;
  logic        r_step;
  logic        r_err;
  logic        r_first;

  logic [15:0] w_value_nxt;
  logic        w_valid_nxt;
  logic        w_step_nxt;
  logic        w_err_nxt;
  logic        w_first_nxt;

  // Output decision at the acceptance edge; pulses default low every cycle
  always_comb begin
    w_value_nxt = r_value;
    w_valid_nxt = 1'b0;
    w_step_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_first_nxt = r_first;
    if (w_accept) begin
      if (w_all_blank) begin
        w_first_nxt = 1'b1;
      end else if (!w_all_legal) begin
        // Value and first-acceptance status are left untouched
        w_err_nxt = 1'b1;
      end else if (r_first || (w_decoded != r_value)) begin
        w_value_nxt = w_decoded;
        w_valid_nxt = 1'b1;
        w_step_nxt  = !r_first && (w_decoded == seg7_succ(r_value));
        w_first_nxt = 1'b0;
      end
      // Legal and equal to the held value: a re-settle after a glitch, silent
    end
  end

  // Registered outputs; pulses clear on the next edge regardless of En
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      r_value <= 16'h0000;
      r_valid <= 1'b0;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_value <= w_value_nxt;
      r_valid <= w_valid_nxt;
      r_step  <= w_step_nxt;
      r_err   <= w_err_nxt;
      r_first <= w_first_nxt;
    end
  end

  assign Value = r_value;
  assign Valid = r_valid;
  assign Step  = r_step;
  assign Err   = r_err;

  // --------------------------------------------------------------------------
  // Optional saturating error counter, updated alongside the Err pulse
  // --------------------------------------------------------------------------
`ifdef SEG7_READBACK_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Count every error pulse, stick at 255, clear only on reset
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      r_err_cnt <= 8'h00;
    end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign ErrCount = r_err_cnt;
`else
  assign ErrCount = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg7_readback.sv
// ============================================================================
//  Module   : tb_seg7_readback
//  Purpose  : Directed bench for seg7_readback with a pulse scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_readback;

  localparam int STABLE_CYCLES = 4;
  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_ERR   = 2;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        En  = 1'b0;
  logic [0:6]  Disp0, Disp1, Disp2, Disp3;
  logic [15:0] Value;
  logic        Valid, Step, Err;
  logic [7:0]  ErrCount;

  seg7_readback #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .En       (En),
    .Disp0    (Disp0),
    .Disp1    (Disp1),
    .Disp2    (Disp2),
    .Disp3    (Disp3),
    .Value    (Value),
    .Valid    (Valid),
    .Step     (Step),
    .Err      (Err),
    .ErrCount (ErrCount)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          err;
    logic [15:0] value;
    bit          step;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_ecnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0001100;
      4'ha: return 7'b0001000;
      4'hb: return 7'b1100000;
      4'hc: return 7'b0110001;
      4'hd: return 7'b1000010;
      4'he: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [27:0] val_pat(input logic [15:0] v);
    return {glyph(v[15:12]), glyph(v[11:8]), glyph(v[7:4]), glyph(v[3:0])};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_pat(input logic [27:0] p);
    {Disp3, Disp2, Disp1, Disp0} = p;
  endtask

  task automatic bump_ecnt();
`ifdef SEG7_READBACK_ERRCNT_EN
    if (exp_ecnt < 255) exp_ecnt++;
`endif
  endtask

  task automatic push(input int at, input bit is_err, input logic [15:0] v, input bit s);
    exp_t e;
    e.cyc   = at;
    e.err   = is_err;
    e.value = v;
    e.step  = s;
    e.ecnt  = 8'(exp_ecnt);
    q.push_back(e);
  endtask

  // Present a pattern (just after an edge) for 'hold' cycles with its expected outcome
  task automatic drive(input logic [27:0] p, input int hold, input int kind,
                       input logic [15:0] ev, input bit es);
    set_pat(p);
    if (kind == K_ERR) bump_ecnt();
    if (kind != K_NONE) push(cyc + STABLE_CYCLES, kind == K_ERR, ev, es);
    repeat (hold) tick();
  endtask

  // Monitor: every pulse must match the head of the scoreboard at the right cycle
  always @(negedge Clk) begin
    exp_t e;
    if (Valid || Err) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'd0, Valid, Err}, 32'd0);
      end else begin
        e = q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_kind", {30'd0, Valid, Err}, e.err ? 32'd1 : 32'd2);
        check("value", {16'd0, Value}, {16'd0, e.value});
        check("step", {31'd0, Step}, {31'd0, e.step});
        check("errcount", {24'd0, ErrCount}, {24'd0, e.ecnt});
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missed_pulse", cyc, e.cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] pat_a;
    logic [27:0] pat_b;
    logic [27:0] blank;
    blank = 28'hFFFFFFF;
    pat_a = {glyph(4'h0), glyph(4'h0), glyph(4'h1), 7'b1111110};
    pat_b = {glyph(4'h0), glyph(4'h0), 7'b1111111, glyph(4'h4)};

    // Reset state
    set_pat(blank);
    Clr = 1'b0;
    En  = 1'b1;
    tick();
    tick();
    @(negedge Clk);
    check("rst_value", {16'd0, Value}, 32'd0);
    check("rst_valid", {31'd0, Valid}, 32'd0);
    check("rst_step", {31'd0, Step}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    check("rst_errcount", {24'd0, ErrCount}, 32'd0);
    tick();
    Clr = 1'b1;
    tick();

    // First acceptance, a step, then a jump
    drive(val_pat(16'h0012), 6, K_VALID, 16'h0012, 1'b0);
    drive(val_pat(16'h0013), 6, K_VALID, 16'h0013, 1'b1);
    drive(val_pat(16'h0015), 6, K_VALID, 16'h0015, 1'b0);

    // Short hold and a one-cycle glitch are never accepted
    drive(val_pat(16'h0013), 2, K_NONE, 16'h0000, 1'b0);
    drive(pat_a, 1, K_NONE, 16'h0000, 1'b0);
    drive(val_pat(16'h0014), 6, K_VALID, 16'h0014, 1'b0);

    // Stable illegal glyph
    drive(pat_a, 6, K_ERR, 16'h0014, 1'b0);

    // Repeated errors separated by a re-settle on the held value (silent)
    for (int i = 0; i < 300; i++) begin
      drive(val_pat(16'h0014), 4, K_NONE, 16'h0000, 1'b0);
      drive((i % 2 == 0) ? pat_b : pat_a, 4, K_ERR, 16'h0014, 1'b0);
    end
    tick();
    @(negedge Clk);
    check("errcount_final", {24'd0, ErrCount}, 32'(exp_ecnt));
    tick();

    // Wraparound step, then blank forces a fresh first acceptance
    drive(val_pat(16'hFFFF), 6, K_VALID, 16'hFFFF, 1'b0);
    drive(val_pat(16'h0000), 6, K_VALID, 16'h0000, 1'b1);
    drive(blank, 6, K_NONE, 16'h0000, 1'b0);
    drive(val_pat(16'h0001), 6, K_VALID, 16'h0001, 1'b0);

    // Enable dropped for 10 cycles in the middle of settling
    set_pat(val_pat(16'h0002));
    push(cyc + STABLE_CYCLES + 10, 1'b0, 16'h0002, 1'b1);
    tick();
    tick();
    En = 1'b0;
    repeat (10) tick();
    En = 1'b1;
    repeat (6) tick();

    // Reset in the middle of settling
    set_pat(val_pat(16'h0007));
    tick();
    tick();
    Clr = 1'b0;
    tick();
    Clr = 1'b1;
    push(cyc + STABLE_CYCLES, 1'b0, 16'h0007, 1'b0);
    @(negedge Clk);
    check("clr_value", {16'd0, Value}, 32'd0);
    check("clr_valid", {31'd0, Valid}, 32'd0);
    check("clr_step", {31'd0, Step}, 32'd0);
    check("clr_err", {31'd0, Err}, 32'd0);
    check("clr_errcount", {24'd0, ErrCount}, 32'd0);
    repeat (8) tick();

    @(negedge Clk);
    check("scoreboard_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
